register_file_write_controller: RTL and testbench

Sequences the single write port of `register_file` and tracks pending writes so that the issue stage never reads a stale operand. The block arbitrates round-robin between two writeback requesters, ALU and memory/load, and registers the winning write for one cycle before presenting it to the register file. It also keeps a 32-entry busy scoreboard: an entry is set when an instruction reserves its destination and cleared when that write reaches the register file. It sits between the execute/memory writeback paths and `register_file`, alongside the issue stage.

---
 rtl/register_file_write_controller_pkg.sv | 13 +
 rtl/register_file_write_controller_if.sv | 47 ++++
 rtl/register_file_write_controller_arbiter.sv | 35 +++
 rtl/register_file_write_controller.sv | 100 ++++++++++
 tb/tb_register_file_write_controller.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_write_controller_pkg.sv
// Shared sizing and requester identifiers for the register file write path.
package register_file_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/register_file_write_controller_if.sv
// Writeback, issue-stage and register-file-side signals of the write controller.
interface register_file_write_controller_if #(
    parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
);

    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [ADDR_WIDTH-1:0] alu_register_i;
    logic [DATA_WIDTH-1:0] alu_data_i;

    logic                  mem_valid_i;
    logic                  mem_ready_o;
    logic [ADDR_WIDTH-1:0] mem_register_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    logic                  reserve_valid_i;
    logic [ADDR_WIDTH-1:0] reserve_register_i;
    logic                  reserve_ready_o;

    logic [ADDR_WIDTH-1:0] rd_register_1_i;
    logic [ADDR_WIDTH-1:0] rd_register_2_i;
    logic                  stall_o;

    logic                  reg_write_o;
    logic [ADDR_WIDTH-1:0] wr_register_o;
    logic [DATA_WIDTH-1:0] wr_data_o;

    modport master (
        output alu_valid_i, alu_register_i, alu_data_i,
        output mem_valid_i, mem_register_i, mem_data_i,
        output reserve_valid_i, reserve_register_i,
        output rd_register_1_i, rd_register_2_i,
        input  alu_ready_o, mem_ready_o, reserve_ready_o, stall_o,
        input  reg_write_o, wr_register_o, wr_data_o
    );

    modport slave (
        input  alu_valid_i, alu_register_i, alu_data_i,
        input  mem_valid_i, mem_register_i, mem_data_i,
        input  reserve_valid_i, reserve_register_i,
        input  rd_register_1_i, rd_register_2_i,
        output alu_ready_o, mem_ready_o, reserve_ready_o, stall_o,
        output reg_write_o, wr_register_o, wr_data_o
    );

endinterface

// File: rtl/register_file_write_controller_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, priority passes to the loser.
module round_robin_arbiter_2
    import register_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_id_e prio;

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (req[REQ_ALU] && req[REQ_MEM]) begin
                if (prio == REQ_MEM) grant = 2'b10;
                else                 grant = 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_ALU;
        end else if (grant[REQ_MEM]) begin
            prio <= REQ_ALU;
        end else if (grant[REQ_ALU]) begin
            prio <= REQ_MEM;
        end
    end

endmodule

// File: rtl/register_file_write_controller.sv
// Register file write sequencer: arbitrates ALU/load writebacks into a one-cycle
// output stage and tracks pending destinations in a busy scoreboard.
module register_file_write_controller #(
    parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = register_file_pkg::NUM_REGS
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    register_file_write_controller_if.slave bus
);

    import register_file_pkg::*;

    logic [1:0]            req;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] sel_register;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] wr_register_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  reserve_ready;

    assign req[REQ_ALU] = bus.alu_valid_i;
    assign req[REQ_MEM] = bus.mem_valid_i;

    round_robin_arbiter_2 u_arbiter (
        .clk   (clock_i),
        .rst   (reset_i),
        .req   (req),
        .grant (grant)
    );

    assign bus.alu_ready_o = grant[REQ_ALU];
    assign bus.mem_ready_o = grant[REQ_MEM];

    always_comb begin
        sel_register = bus.alu_register_i;
        sel_data     = bus.alu_data_i;
        if (grant[REQ_MEM]) begin
            sel_register = bus.mem_register_i;
            sel_data     = bus.mem_data_i;
        end
    end

    // Writes to x0 are accepted but presented as an all-zero idle cycle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            reg_write_q   <= 1'b0;
            wr_register_q <= '0;
            wr_data_q     <= '0;
        end else if (grant != 2'b00) begin
            if (sel_register != '0) begin
                reg_write_q   <= 1'b1;
                wr_register_q <= sel_register;
                wr_data_q     <= sel_data;
            end else begin
                reg_write_q   <= 1'b0;
                wr_register_q <= '0;
                wr_data_q     <= '0;
            end
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    // A write captured just before reset asserts is masked so it never reaches the register file.
    assign bus.reg_write_o   = reg_write_q & ~reset_i;
    assign bus.wr_register_o = wr_register_q;
    assign bus.wr_data_o     = wr_data_q;

    assign reserve_ready       = bus.reserve_valid_i & ~busy[bus.reserve_register_i] & ~reset_i;
    assign bus.reserve_ready_o = reserve_ready;

    always_comb begin
        busy_next = busy;
        if (bus.reg_write_o) begin
            busy_next[wr_register_q] = 1'b0;
        end
        if (reserve_ready) begin
            busy_next[bus.reserve_register_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign bus.stall_o = busy[bus.rd_register_1_i] | busy[bus.rd_register_2_i];

endmodule

// File: tb/tb_register_file_write_controller.sv
// Bench for register_file_write_controller: vector table for arbitration plus
// hand-written sequences for scoreboard, x0 and reset corner cases.
module tb_register_file_write_controller;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clock_i = 1'b0;
    logic reset_i;

    always #5 clock_i = ~clock_i;

    register_file_write_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_file_write_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (32)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // Stand-in for register_file: stores on reg_write_o at the rising edge.
    logic [DW-1:0] rf [32];
    always @(posedge clock_i) begin
        if (bus.reg_write_o) rf[bus.wr_register_o] <= bus.wr_data_o;
    end

    typedef struct {
        logic          av;
        logic [AW-1:0] ar;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] mr;
        logic [DW-1:0] md;
        logic          exp_ar;
        logic          exp_mr;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    wr_t         exp_q[$];
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid_i        = 1'b0;
        bus.alu_register_i     = '0;
        bus.alu_data_i         = '0;
        bus.mem_valid_i        = 1'b0;
        bus.mem_register_i     = '0;
        bus.mem_data_i         = '0;
        bus.reserve_valid_i    = 1'b0;
        bus.reserve_register_i = '0;
        bus.rd_register_1_i    = '0;
        bus.rd_register_2_i    = '0;
    endtask

    // Every register must read as not busy; requesters must be idle while sweeping.
    task automatic check_busy_clear(input string name);
        for (int i = 0; i < 32; i++) begin
            bus.rd_register_1_i = AW'(i);
            bus.rd_register_2_i = '0;
            #1;
            chk(name, {31'b0, bus.stall_o}, 32'd0);
        end
        bus.rd_register_1_i = '0;
    endtask

    function automatic vec_t mk(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                                input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                                input logic ear, input logic emr);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md;
        v.exp_ar = ear; v.exp_mr = emr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] last_r;
        logic [DW-1:0] last_d;
        wr_t           e;

        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Priority starts at ALU after reset and flips to the loser after each grant.
        vecs[0]  = mk(1, 5'd1,  32'h11, 1, 5'd2,  32'h22, 1, 0);
        vecs[1]  = mk(1, 5'd4,  32'h44, 1, 5'd2,  32'h22, 0, 1);
        vecs[2]  = mk(1, 5'd4,  32'h44, 1, 5'd6,  32'h66, 1, 0);
        vecs[3]  = mk(1, 5'd8,  32'h88, 1, 5'd6,  32'h66, 0, 1);
        vecs[4]  = mk(1, 5'd8,  32'h88, 0, 5'd0,  32'h0,  1, 0);
        vecs[5]  = mk(0, 5'd0,  32'h0,  1, 5'd9,  32'h99, 0, 1);
        vecs[6]  = mk(1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB, 1, 0);
        vecs[7]  = mk(1, 5'd12, 32'hCC, 1, 5'd11, 32'hBB, 0, 1);
        vecs[8]  = mk(0, 5'd0,  32'h0,  0, 5'd0,  32'h0,  0, 0);
        vecs[9]  = mk(0, 5'd0,  32'h0,  1, 5'd0,  32'h1234, 0, 1);
        vecs[10] = mk(1, 5'd31, 32'hFFFF_FFFF, 1, 5'd30, 32'h3030, 1, 0);
        vecs[11] = mk(0, 5'd0,  32'h0,  1, 5'd30, 32'h3030, 0, 1);

        idle_inputs();
        reset_i = 1'b1;
        bus.alu_valid_i        = 1'b1;
        bus.alu_register_i     = 5'd1;
        bus.mem_valid_i        = 1'b1;
        bus.mem_register_i     = 5'd2;
        bus.reserve_valid_i    = 1'b1;
        bus.reserve_register_i = 5'd3;

        // Reset held two cycles with everything requesting.
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_alu_ready", {31'b0, bus.alu_ready_o}, 32'd0);
            chk("rst_mem_ready", {31'b0, bus.mem_ready_o}, 32'd0);
            chk("rst_reserve_ready", {31'b0, bus.reserve_ready_o}, 32'd0);
            chk("rst_reg_write", {31'b0, bus.reg_write_o}, 32'd0);
        end
        chk("rst_wr_register", {27'b0, bus.wr_register_o}, 32'd0);
        chk("rst_wr_data", bus.wr_data_o, 32'd0);
        bus.reserve_valid_i = 1'b0;
        check_busy_clear("rst_busy_clear");
        step();
        reset_i = 1'b0;

        last_r = '0;
        last_d = '0;
        for (int i = 0; i < 12; i++) begin
            bus.alu_valid_i    = vecs[i].av;
            bus.alu_register_i = vecs[i].ar;
            bus.alu_data_i     = vecs[i].ad;
            bus.mem_valid_i    = vecs[i].mv;
            bus.mem_register_i = vecs[i].mr;
            bus.mem_data_i     = vecs[i].md;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), {31'b0, bus.alu_ready_o}, {31'b0, vecs[i].exp_ar});
            chk($sformatf("vec%0d_mem_ready", i), {31'b0, bus.mem_ready_o}, {31'b0, vecs[i].exp_mr});
            if (vecs[i].exp_ar || vecs[i].exp_mr) begin
                e.r = vecs[i].exp_ar ? vecs[i].ar : vecs[i].mr;
                e.d = vecs[i].exp_ar ? vecs[i].ad : vecs[i].md;
                if (e.r == '0) begin
                    e.we = 1'b0;
                    e.d  = '0;
                end else begin
                    e.we = 1'b1;
                end
                last_r = e.r;
                last_d = e.d;
            end else begin
                e.we = 1'b0;
                e.r  = last_r;
                e.d  = last_d;
            end
            exp_q.push_back(e);
            step();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_reg_write", i), {31'b0, bus.reg_write_o}, {31'b0, e.we});
            chk($sformatf("vec%0d_wr_register", i), {27'b0, bus.wr_register_o}, {27'b0, e.r});
            chk($sformatf("vec%0d_wr_data", i), bus.wr_data_o, e.d);
        end
        idle_inputs();
        step();
        chk("rf_r2", rf[2], 32'h22);
        chk("rf_r6", rf[6], 32'h66);
        chk("rf_r31", rf[31], 32'hFFFF_FFFF);
        chk("rf_r0", rf[0], 32'h0);
        check_busy_clear("unreserved_busy_clear");
        step();

        // Single reserved write: stall until data is readable two cycles after the grant.
        bus.reserve_valid_i    = 1'b1;
        bus.reserve_register_i = 5'd5;
        #1;
        chk("sw_reserve_ready", {31'b0, bus.reserve_ready_o}, 32'd1);
        step();
        bus.reserve_valid_i = 1'b0;
        bus.rd_register_1_i = 5'd5;
        bus.alu_valid_i     = 1'b1;
        bus.alu_register_i  = 5'd5;
        bus.alu_data_i      = 32'hDEAD_BEEF;
        #1;
        chk("sw_alu_ready", {31'b0, bus.alu_ready_o}, 32'd1);
        chk("sw_stall_n", {31'b0, bus.stall_o}, 32'd1);
        step();
        bus.alu_valid_i = 1'b0;
        chk("sw_reg_write", {31'b0, bus.reg_write_o}, 32'd1);
        chk("sw_wr_register", {27'b0, bus.wr_register_o}, 32'd5);
        chk("sw_wr_data", bus.wr_data_o, 32'hDEAD_BEEF);
        chk("sw_stall_n1", {31'b0, bus.stall_o}, 32'd1);
        step();
        chk("sw_reg_write_n2", {31'b0, bus.reg_write_o}, 32'd0);
        chk("sw_stall_n2", {31'b0, bus.stall_o}, 32'd0);
        chk("sw_rf_r5", rf[5], 32'hDEAD_BEEF);
        idle_inputs();

        // x0: reservation accepted without effect, write accepted but never presented.
        bus.reserve_valid_i    = 1'b1;
        bus.reserve_register_i = 5'd0;
        #1;
        chk("x0_reserve_ready", {31'b0, bus.reserve_ready_o}, 32'd1);
        step();
        bus.reserve_valid_i = 1'b0;
        bus.mem_valid_i     = 1'b1;
        bus.mem_register_i  = 5'd0;
        bus.mem_data_i      = 32'h1234;
        #1;
        chk("x0_stall", {31'b0, bus.stall_o}, 32'd0);
        chk("x0_mem_ready", {31'b0, bus.mem_ready_o}, 32'd1);
        step();
        bus.mem_valid_i = 1'b0;
        chk("x0_reg_write", {31'b0, bus.reg_write_o}, 32'd0);
        chk("x0_wr_register", {27'b0, bus.wr_register_o}, 32'd0);
        chk("x0_wr_data", bus.wr_data_o, 32'd0);
        step();
        chk("x0_reg_write_after", {31'b0, bus.reg_write_o}, 32'd0);

        // WAW: reservation refused while busy, including the cycle the clearing write is presented.
        bus.reserve_valid_i    = 1'b1;
        bus.reserve_register_i = 5'd7;
        bus.rd_register_1_i    = 5'd7;
        #1;
        chk("waw_first_ready", {31'b0, bus.reserve_ready_o}, 32'd1);
        step();
        bus.mem_valid_i    = 1'b1;
        bus.mem_register_i = 5'd7;
        bus.mem_data_i     = 32'h77;
        #1;
        chk("waw_busy_ready", {31'b0, bus.reserve_ready_o}, 32'd0);
        chk("waw_stall", {31'b0, bus.stall_o}, 32'd1);
        chk("waw_mem_ready", {31'b0, bus.mem_ready_o}, 32'd1);
        step();
        bus.mem_valid_i = 1'b0;
        chk("waw_reg_write", {31'b0, bus.reg_write_o}, 32'd1);
        chk("waw_wr_register", {27'b0, bus.wr_register_o}, 32'd7);
        chk("waw_same_cycle_ready", {31'b0, bus.reserve_ready_o}, 32'd0);
        step();
        chk("waw_retry_ready", {31'b0, bus.reserve_ready_o}, 32'd1);
        chk("waw_rf_r7", rf[7], 32'h77);
        step();
        bus.reserve_valid_i = 1'b0;
        #1;
        chk("waw_rebusy_stall", {31'b0, bus.stall_o}, 32'd1);
        bus.alu_valid_i    = 1'b1;
        bus.alu_register_i = 5'd7;
        bus.alu_data_i     = 32'h70;
        step();
        bus.alu_valid_i = 1'b0;
        step();
        chk("waw_cleared_stall", {31'b0, bus.stall_o}, 32'd0);
        chk("waw_rf_r7_second", rf[7], 32'h70);
        idle_inputs();

        // Reset right after an ALU write to r3 is captured.
        bus.reserve_valid_i    = 1'b1;
        bus.reserve_register_i = 5'd3;
        step();
        bus.reserve_valid_i = 1'b0;
        bus.rd_register_1_i = 5'd3;
        bus.alu_valid_i     = 1'b1;
        bus.alu_register_i  = 5'd3;
        bus.alu_data_i      = 32'h33;
        #1;
        chk("mr_alu_ready", {31'b0, bus.alu_ready_o}, 32'd1);
        chk("mr_stall", {31'b0, bus.stall_o}, 32'd1);
        step();
        reset_i         = 1'b1;
        bus.alu_valid_i = 1'b0;
        #1;
        chk("mr_reg_write_0", {31'b0, bus.reg_write_o}, 32'd0);
        step();
        chk("mr_reg_write_1", {31'b0, bus.reg_write_o}, 32'd0);
        chk("mr_stall_cleared", {31'b0, bus.stall_o}, 32'd0);
        step();
        reset_i = 1'b0;
        #1;
        chk("mr_reg_write_2", {31'b0, bus.reg_write_o}, 32'd0);
        chk("mr_wr_register", {27'b0, bus.wr_register_o}, 32'd0);
        chk("mr_wr_data", bus.wr_data_o, 32'd0);
        step();
        chk("mr_reg_write_3", {31'b0, bus.reg_write_o}, 32'd0);
        chk("mr_rf_r3", rf[3], 32'd0);
        check_busy_clear("mr_busy_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
